uart_rx_frame_ctrl: RTL

Sequencer that sits directly behind the UARTRx receiver. It consumes received bytes, hunts for a framed command (SYNC, ADDR, LEN, PAYLOAD, CHK) and buffers the payload. Only after the checksum verifies does it commit the payload as sequential writes to a downstream register/port file; this replaces the ad-hoc Top-level byte capture. Malformed, oversize or stalled frames are discarded and each is flagged with a one-cycle error pulse.

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame sequencer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    LEN,
    PAYLOAD,
    CHK,
    COMMIT,
    DONE
  } frame_state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_MAX_LEN   = 8;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: one write port fed while receiving, one read port used during commit.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int AW      = cnt_width(MAX_LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Framed-command sequencer behind the UART receiver: SYNC, ADDR, LEN, PAYLOAD, CHK,
// then commits the buffered payload as sequential register writes.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         MAX_LEN        = DEF_MAX_LEN,
  parameter int         ADDR_WIDTH     = 4,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                  sourceClk,
  input  logic                  reset,
  input  logic                  rx_start,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_complete,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_chk,
  output logic                  err_len,
  output logic                  err_timeout
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = cnt_width(MAX_LEN);
  localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  frame_state_e          state_q, state_nxt;
  logic                  rx_complete_q;
  logic                  pend_vld_q;
  logic [7:0]            pend_byte_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]      len_q, idx_q;
  logic [7:0]            chk_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic                  rx_ev, pend_use, ev, in_frame, to_hit, idx_last;
  logic                  len_bad, chk_bad, buf_we;
  logic [7:0]            ev_byte, rd_data;

  // The pending slot holds a byte that arrived during COMMIT/DONE; it is replayed first.
  assign rx_ev    = rx_complete & ~rx_complete_q;
  assign pend_use = pend_vld_q && (state_q != COMMIT) && (state_q != DONE);
  assign ev       = rx_ev | pend_use;
  assign ev_byte  = pend_use ? pend_byte_q : rx_byte;
  assign in_frame = (state_q == ADDR) || (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign to_hit   = in_frame && (to_cnt_q == TO_LAST);
  assign idx_last = (idx_q + IDX_W'(1)) == len_q;
  assign buf_we   = ev && !to_hit && (state_q == PAYLOAD);

  always_comb begin
    state_nxt = state_q;
    len_bad   = 1'b0;
    chk_bad   = 1'b0;
    if (to_hit) begin
      state_nxt = HUNT;
    end else begin
      unique case (state_q)
        HUNT:    if (ev && ev_byte == SYNC_BYTE) state_nxt = ADDR;
        ADDR:    if (ev) state_nxt = LEN;
        LEN: begin
          if (ev) begin
            if (ev_byte > 8'(MAX_LEN)) begin
              len_bad   = 1'b1;
              state_nxt = HUNT;
            end else if (ev_byte == 8'h00) begin
              state_nxt = CHK;
            end else begin
              state_nxt = PAYLOAD;
            end
          end
        end
        PAYLOAD: if (ev && idx_last) state_nxt = CHK;
        CHK: begin
          if (ev) begin
            if (ev_byte == chk_q) begin
              state_nxt = (len_q == '0) ? DONE : COMMIT;
            end else begin
              chk_bad   = 1'b1;
              state_nxt = HUNT;
            end
          end
        end
        COMMIT:  if (idx_last) state_nxt = DONE;
        DONE:    state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge sourceClk) begin
    if (reset) begin
      state_q       <= HUNT;
      rx_complete_q <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_byte_q   <= 8'h00;
      idx_q         <= '0;
      chk_q         <= 8'h00;
      to_cnt_q      <= '0;
      err_chk       <= 1'b0;
      err_len       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      rx_complete_q <= rx_complete;
      err_chk       <= chk_bad;
      err_len       <= len_bad;
      err_timeout   <= to_hit;

      if (rx_ev && (pend_use || state_q == COMMIT || state_q == DONE)) begin
        pend_vld_q  <= 1'b1;
        pend_byte_q <= rx_byte;
      end else if (pend_use) begin
        pend_vld_q  <= 1'b0;
      end

      // rx_start keeps a byte that is still being shifted in from timing out.
      if (!in_frame || ev || rx_start) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_LAST) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      if (ev && !to_hit) begin
        unique case (state_q)
          ADDR:    chk_q <= ev_byte;
          LEN: begin
            chk_q <= chk_q ^ ev_byte;
            idx_q <= '0;
          end
          PAYLOAD: begin
            chk_q <= chk_q ^ ev_byte;
            idx_q <= idx_q + IDX_W'(1);
          end
          CHK:     idx_q <= '0;
          default: ;
        endcase
      end
      if (state_q == COMMIT) idx_q <= idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge sourceClk) begin
    if (ev && !to_hit && state_q == ADDR) base_q <= ev_byte[ADDR_WIDTH-1:0];
    if (ev && !to_hit && state_q == LEN)  len_q  <= ev_byte[IDX_W-1:0];
  end

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (BUF_AW)
  ) u_buf (
    .clk     (sourceClk),
    .wr_en   (buf_we),
    .wr_idx  (idx_q[BUF_AW-1:0]),
    .wr_data (ev_byte),
    .rd_idx  (idx_q[BUF_AW-1:0]),
    .rd_data (rd_data)
  );

  assign wr_en      = (state_q == COMMIT);
  assign wr_addr    = wr_en ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign wr_data    = wr_en ? rd_data : 8'h00;
  assign busy       = (state_q != HUNT);
  assign frame_done = (state_q == DONE);

endmodule
